// File: rtl/std_debouncer_pkg.sv
// Shared types and helpers for the multi-bit input debouncer.
package std_debouncer_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  // Width of a counter that must reach STABLE_CYCLES-1; never below one bit.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/std_debouncer_channel.sv
// Single-bit debounce FSM: o_data follows the synchronised input only after
// it has differed from o_data for STABLE_CYCLES consecutive cycles.
module std_debouncer_channel
  import std_debouncer_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic INITIAL_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_sync,
  output logic o_data,
  output logic o_busy
);

  localparam int             CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  state_e        state;
  logic [CW-1:0] cnt;

  // NOTE: state, counter and o_data all use non-blocking assignments so every
  // branch reads the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state  <= STABLE;
      cnt    <= '0;
      o_data <= INITIAL_VALUE;
    end else begin
      case (state)
        STABLE: begin
          if (i_sync != o_data) begin
            if (STABLE_CYCLES == 1) begin
              o_data <= i_sync;
            end else begin
              state <= COUNTING;
              cnt   <= CW'(1);
            end
          end
        end
        COUNTING: begin
          if (i_sync == o_data) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            o_data <= i_sync;
            state  <= STABLE;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy = (state == COUNTING);

endmodule

// File: rtl/std_debouncer.sv
// Multi-bit debouncer: synchroniser chain into i_clk, then one independent
// debounce channel per bit.
module std_debouncer
  import std_debouncer_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               SYNC_STAGES   = 2,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_busy
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("std_debouncer: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable_cycles
    $error("std_debouncer: STABLE_CYCLES=%0d outside 1..65535", STABLE_CYCLES);
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // NOTE: the synchroniser array is reset like any other flop: a clear must
  // flush stale samples, otherwise they would re-qualify after release.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INITIAL_VALUE;
    end else begin
      sync_q[0] <= i_data;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_ch
    std_debouncer_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INITIAL_VALUE (INITIAL_VALUE[b])
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_clear),
      .i_sync  (sync_q[SYNC_STAGES-1][b]),
      .o_data  (o_data[b]),
      .o_busy  (o_busy[b])
    );
  end

endmodule

// File: tb/tb_std_debouncer.sv
// Bench for std_debouncer: a 4-cycle instance and a 1-cycle boundary instance
// share the same stimulus and are checked against a sample-window model.
module tb_std_debouncer;

  localparam int SS = 2;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_clear;
  logic [1:0] i_data;
  logic [1:0] a_data, a_busy, b_data, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int         n_cyc [2] = '{4, 1};
  logic [1:0] pipe  [2][SS];
  logic [7:0] hist  [2][2];
  int         valid [2][2];
  logic [1:0] m_data[2];
  logic [1:0] m_busy[2];

  always #5 i_clk = ~i_clk;

  std_debouncer #(.WIDTH(2), .SYNC_STAGES(SS), .STABLE_CYCLES(4), .INITIAL_VALUE(2'b00)) u_dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_data(i_data),
    .o_data(a_data), .o_busy(a_busy));

  std_debouncer #(.WIDTH(2), .SYNC_STAGES(SS), .STABLE_CYCLES(1), .INITIAL_VALUE(2'b00)) u_dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_data(i_data),
    .o_data(b_data), .o_busy(b_busy));

  // Output flips once the last N synchronised samples (since reset) all differ
  // from it; a bit is busy while its newest sample disagrees with the output.
  task automatic model_step();
    logic [1:0] s;
    logic       all_diff;
    for (int k = 0; k < 2; k++) begin
      if (i_rst || i_clear) begin
        for (int j = 0; j < SS; j++) pipe[k][j] = 2'b00;
        m_data[k] = 2'b00;
        m_busy[k] = 2'b00;
        for (int b = 0; b < 2; b++) begin
          hist[k][b]  = '0;
          valid[k][b] = 0;
        end
      end else begin
        s = pipe[k][SS-1];
        for (int j = SS - 1; j > 0; j--) pipe[k][j] = pipe[k][j-1];
        pipe[k][0] = i_data;
        for (int b = 0; b < 2; b++) begin
          hist[k][b] = {hist[k][b][6:0], s[b]};
          if (valid[k][b] < 8) valid[k][b]++;
          all_diff = (valid[k][b] >= n_cyc[k]);
          for (int i = 0; i < n_cyc[k]; i++)
            if (hist[k][b][i] == m_data[k][b]) all_diff = 1'b0;
          if (all_diff) m_data[k][b] = s[b];
          m_busy[k][b] = (hist[k][b][0] != m_data[k][b]);
        end
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    return {m_data[0], m_busy[0], m_data[1], m_busy[1]};
  endfunction

  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle(input logic [1:0] v);
    i_data = v;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    i_data = 2'b11; i_clear = 1'b0; i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    n_tests++;
    if (a_data !== 2'b00 || a_busy !== 2'b00 || b_data !== 2'b00 || b_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: a_data=%b a_busy=%b b_data=%b b_busy=%b want all 00",
               a_data, a_busy, b_data, b_busy);
    end
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_tests++;
      if ({a_data, a_busy, b_data, b_busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL reset_model e=%0d: got %b want %b", e, {a_data, a_busy, b_data, b_busy}, model_vec());
      end
    end
    n_tests++;
    if (a_data !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_qualify: a_data=%b want 11", a_data);
    end
  endtask

  task automatic test_clean_step();
    settle(2'b00);
    i_data = 2'b01;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_tests++;
      if (a_busy[0] !== (e >= 3 && e <= 5) || a_data[0] !== (e >= 6)) begin
        n_fail++;
        $display("FAIL clean_step e=%0d: busy0=%b data0=%b want busy0=%b data0=%b",
                 e, a_busy[0], a_data[0], (e >= 3 && e <= 5), (e >= 6));
      end
      n_tests++;
      if ({a_data, a_busy, b_data, b_busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL clean_model e=%0d: got %b want %b", e, {a_data, a_busy, b_data, b_busy}, model_vec());
      end
    end
  endtask

  task automatic test_glitch();
    logic seen_busy;
    seen_busy = 1'b0;
    settle(2'b00);
    i_data = 2'b01;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 3) i_data = 2'b00;
      seen_busy |= a_busy[0];
      n_tests++;
      if (a_data[0] !== 1'b0 || {a_data, a_busy, b_data, b_busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL glitch e=%0d: got %b want %b (a_data0 must stay 0)",
                 e, {a_data, a_busy, b_data, b_busy}, model_vec());
      end
    end
    n_tests++;
    if (!seen_busy) begin
      n_fail++;
      $display("FAIL glitch_busy: busy0 never asserted, want a pulse");
    end
  endtask

  task automatic test_clear_mid_count();
    settle(2'b00);
    i_data = 2'b01;
    repeat (3) tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    n_tests++;
    if (a_data !== 2'b00 || a_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_edge: a_data=%b a_busy=%b want 00 00", a_data, a_busy);
    end
    for (int e = 5; e <= 10; e++) begin
      tick();
      n_tests++;
      if (a_data[0] !== (e == 10) || {a_data, a_busy, b_data, b_busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL clear_requalify e=%0d: got %b want %b, data0 want %b",
                 e, {a_data, a_busy, b_data, b_busy}, model_vec(), (e == 10));
      end
    end
  endtask

  task automatic test_opposing();
    settle(2'b01);
    i_data = 2'b10;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_tests++;
      if (a_data !== ((e < 6) ? 2'b01 : 2'b10) ||
          a_busy !== ((e >= 3 && e <= 5) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL opposing e=%0d: a_data=%b a_busy=%b want %b %b", e, a_data, a_busy,
                 ((e < 6) ? 2'b01 : 2'b10), ((e >= 3 && e <= 5) ? 2'b11 : 2'b00));
      end
    end
  endtask

  task automatic test_stable_one();
    settle(2'b00);
    i_data = 2'b01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_tests++;
      if (b_data[0] !== (e >= 3) || b_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL stable_one e=%0d: b_data0=%b b_busy=%b want %b 00", e, b_data[0], b_busy, (e >= 3));
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        i_data = 2'($urandom_range(0, 3));
        hold   = $urandom_range(1, 7);
      end
      hold--;
      i_clear = ($urandom_range(0, 59) == 0);
      i_rst   = ($urandom_range(0, 149) == 0);
      tick();
      n_tests++;
      if ({a_data, a_busy, b_data, b_busy} !== model_vec()) begin
        n_fail++;
        $display("FAIL random c=%0d: got %b want %b", c, {a_data, a_busy, b_data, b_busy}, model_vec());
      end
    end
    i_clear = 1'b0;
    i_rst   = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_data = 2'b00;
    test_reset();
    test_clean_step();
    test_glitch();
    test_clear_mid_count();
    test_opposing();
    test_stable_one();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/std_debouncer.md
Name: std_debouncer

Overview:
- Input-conditioning stage that sits directly upstream of the edge detector.
- Synchronises a multi-bit asynchronous level input (switches, external strobes) into the i_clk domain.
- Rejects glitches shorter than a programmable number of cycles.
- Presents a clean, glitch-free level on o_data, suitable for feeding straight into the edge detector's i_data.

Parameters:
- WIDTH, 1: number of independent input bits; each bit is debounced separately.
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- STABLE_CYCLES, 4: consecutive cycles a synchronised bit must differ from o_data before o_data follows it; legal range 1..65535.
- INITIAL_VALUE, '0 (WIDTH bits): value of the synchroniser chain and o_data after reset or clear.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst  input  1  reset, synchronous, active-high.
- i_clear  input  1  synchronous clear; same effect as reset.
- i_data  input  WIDTH  raw asynchronous input levels.
- o_data  output  WIDTH  debounced level, registered.
- o_busy  output  WIDTH  per bit: 1 while the bit is in COUNTING.

Behaviour:
- Reset and clear:
  - i_rst is sampled on the rising edge of i_clk; priority is i_rst > i_clear > normal operation.
  - On either, every sync stage := INITIAL_VALUE, o_data := INITIAL_VALUE, all counters := 0, all bits go to STABLE, o_busy := 0.
  - Reset or clear mid-count discards the pending change; no partial count survives.
- Synchroniser:
  - sync[0] <= i_data; sync[k] <= sync[k-1].
  - s = sync[SYNC_STAGES-1]; no logic is placed between stages.
- Per-bit FSM: states STABLE and COUNTING, plus counter cnt of width $clog2(STABLE_CYCLES+1).
  - STABLE, s == o_data: hold, cnt = 0.
  - STABLE, s != o_data, STABLE_CYCLES == 1: o_data <= s; stay in STABLE.
  - STABLE, s != o_data, STABLE_CYCLES > 1: go to COUNTING with cnt <= 1.
  - COUNTING, s == o_data: glitch rejected; go to STABLE with cnt <= 0; o_data unchanged.
  - COUNTING, s != o_data, cnt == STABLE_CYCLES-1: o_data <= s; go to STABLE with cnt <= 0.
  - COUNTING, otherwise: cnt <= cnt + 1.
  - The counter never wraps; the terminal compare ends counting.
- Latency: i_data change set up before edge E1 appears on o_data after edge E(SYNC_STAGES + STABLE_CYCLES). With defaults, o_data changes after edge 6.
- Pulse rejection: a synchronised pulse lasting fewer than STABLE_CYCLES cycles never reaches o_data.
- Bit independence: bits are fully independent. Simultaneous changes on several bits are handled in parallel, with no cross-bit interaction.
- o_busy is a direct decode of the COUNTING state, not delayed.
- Output ordering: o_data changes at most once per STABLE_CYCLES cycles per bit, so the downstream edge detector sees at most one edge per qualified transition.

Decomposition:
- Shared package std_debouncer_pkg holds:
  - enum state_e {STABLE, COUNTING};
  - function cnt_width(STABLE_CYCLES), returning the counter width.
- Sub-module std_debouncer_channel is the single-bit FSM plus counter; it is instantiated WIDTH times in a generate loop.
- The top module owns the synchroniser chain and the parameter legality checks (elaboration-time $error for out-of-range SYNC_STAGES or STABLE_CYCLES).

Test Plan (WIDTH=2, SYNC_STAGES=2, STABLE_CYCLES=4, INITIAL_VALUE=2'b00 unless noted):
- Reset: hold i_rst=1 for 3 cycles with i_data=2'b11, then release → o_data=2'b00 and o_busy=2'b00 on the first edge after release; o_data=2'b11 after 6 further edges.
- Clean step: i_data bit0 0→1 before edge 1, held → o_busy[0]=1 after edges 3..5; o_data[0]=1 after edge 6; o_busy[0]=0 after edge 6.
- Glitch rejection: i_data bit0 high for exactly 3 cycles, then low → o_busy[0] pulses; o_data[0] stays 0 throughout (checked for 20 cycles).
- Clear mid-count: i_data=2'b01; assert i_clear for 1 cycle at edge 4 → o_data=2'b00, o_busy=2'b00 after edge 4. After release, bit0 re-qualifies: o_data[0]=1 exactly 6 edges after the clear edge.
- Simultaneous and opposing: start from o_data=2'b01; i_data 2'b01→2'b10 on one edge → both bits count in parallel; o_data=2'b10 after edge 6, with no intermediate 2'b00 or 2'b11.
- Boundary STABLE_CYCLES=1: i_data bit0 step → o_data[0] follows after edge 3; o_busy never asserts.
